// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch sequencer bus bundle: PC control, memory read, decode handshake
interface fetch_ctrl_if #(
  parameter int WIDTH = 16
);
  // PC register side
  logic [WIDTH-1:0] pc_in;
  logic             pc_we;
  logic             pc_inc;
  logic             pc_l;
  logic [WIDTH-1:0] pc_load;
  // Memory read side
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_data;
  // Decode side
  logic [WIDTH-1:0] ir_out;
  logic [WIDTH-1:0] ir_pc;
  logic             ir_valid;
  logic             ir_ready;
  logic             br_take;
  logic [WIDTH-1:0] br_target;
  // Status
  logic             fault;

  // The fetch sequencer
  modport master (
    input  pc_in, mem_ack, mem_data, ir_ready, br_take, br_target,
    output pc_we, pc_inc, pc_l, pc_load, mem_req, mem_addr,
           ir_out, ir_pc, ir_valid, fault
  );

  // The surrounding PC, memory and decode logic
  modport slave (
    output pc_in, mem_ack, mem_data, ir_ready, br_take, br_target,
    input  pc_we, pc_inc, pc_l, pc_load, mem_req, mem_addr,
           ir_out, ir_pc, ir_valid, fault
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer between PC register, memory and decode
module fetch_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          re,
  fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    wait_cnt;
  logic [WIDTH-1:0] ir_out_q;
  logic [WIDTH-1:0] ir_pc_q;
  logic             handshake;

  // Decode accepts the held instruction this cycle
  assign handshake = (state == HOLD) && bus.ir_ready;

  // Sequencer state, wait counter and instruction register
  always_ff @(posedge clk or posedge re) begin
    if (re) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ir_out_q <= '0;
      ir_pc_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (bus.mem_ack) begin
            // Capture word and its address; PC is not written in FETCH so pc_in is still the fetch address
            ir_out_q <= bus.mem_data;
            ir_pc_q  <= bus.pc_in;
            wait_cnt <= '0;
            state    <= HOLD;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // mem_req has now been high for exactly TIMEOUT cycles
            wait_cnt <= '0;
            state    <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (bus.ir_ready) state <= FETCH;
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state plus handshake inputs
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    bus.ir_valid = 1'b0;
    bus.fault    = 1'b0;
    bus.pc_we    = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_l     = 1'b0;
    bus.pc_load  = '0;
    case (state)
      FETCH: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = bus.pc_in;
      end
      HOLD: begin
        bus.ir_valid = 1'b1;
        if (handshake) begin
          bus.pc_we = 1'b1;
          if (bus.br_take) begin
            bus.pc_l    = 1'b1;
            bus.pc_load = bus.br_target;
          end else begin
            bus.pc_inc = 1'b1;
          end
        end
      end
      FAULT: begin
        bus.fault = 1'b1;
      end
      default: begin
        bus.mem_req = 1'b0;
      end
    endcase
  end

  assign bus.ir_out = ir_out_q;
  assign bus.ir_pc  = ir_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with PC model and IR scoreboard
module tb_fetch_ctrl;
  localparam int W  = 16;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic re  = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.WIDTH(W)) bus ();

  fetch_ctrl #(.WIDTH(W), .TIMEOUT(TO), .CW(8)) dut (
    .clk (clk),
    .re  (re),
    .bus (bus.master)
  );

  // External PC register model, reset/preset separately from the DUT
  logic [W-1:0] pc;
  logic [W-1:0] pc_init;
  logic         pc_clr;
  always @(posedge clk) begin
    if (pc_clr)          pc <= pc_init;
    else if (bus.pc_we)  pc <= bus.pc_l ? bus.pc_load : pc + 1'b1;
  end
  assign bus.pc_in = pc;

  typedef struct {
    logic [W-1:0] data;
    int           ack_delay;
    int           stall;
    logic         br;
    logic [W-1:0] tgt;
    logic [W-1:0] exp_addr;
    logic [W-1:0] exp_next;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] pc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [W-1:0] init);
    re = 1'b1; pc_init = init; pc_clr = 1'b1;
    bus.mem_ack = 1'b0; bus.ir_ready = 1'b0; bus.br_take = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pc_clr = 1'b0; re = 1'b0;
  endtask

  // Bounded wait for mem_req; checks at negedge+1
  task automatic wait_req();
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_req) return;
      @(negedge clk); #1;
    end
    n_cmp++; n_err++;
    $display("FAIL wait_req: mem_req never rose within 40 cycles");
  endtask

  // One full fetch/hold/handshake; entered in a FETCH cycle at negedge+1
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    chk($sformatf("v%0d_addr", idx), bus.mem_addr, v.exp_addr);
    sb.push_back('{data: v.data, pc: v.exp_addr});
    for (int d = 0; d < v.ack_delay; d++) begin
      bus.mem_ack = 1'b0;
      @(negedge clk); #1;
    end
    chk($sformatf("v%0d_req_before_ack", idx), bus.mem_req, 1'b1);
    bus.mem_ack = 1'b1; bus.mem_data = v.data;
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.mem_data = 16'h5A5A;
    #1;
    chk($sformatf("v%0d_ir_valid", idx), bus.ir_valid, 1'b1);
    chk($sformatf("v%0d_hold_req", idx), bus.mem_req, 1'b0);
    if (bus.ir_valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL v%0d_sb: ir_valid with empty scoreboard", idx);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_ir_out", idx), bus.ir_out, e.data);
        chk($sformatf("v%0d_ir_pc", idx), bus.ir_pc, e.pc);
      end
    end
    for (int s = 0; s < v.stall; s++) begin
      bus.ir_ready = 1'b0; bus.br_take = s[0]; bus.br_target = 16'hDEAD;
      #1;
      chk($sformatf("v%0d_stall%0d_we", idx, s), bus.pc_we, 1'b0);
      chk($sformatf("v%0d_stall%0d_req", idx, s), bus.mem_req, 1'b0);
      chk($sformatf("v%0d_stall%0d_valid", idx, s), bus.ir_valid, 1'b1);
      chk($sformatf("v%0d_stall%0d_ir", idx, s), bus.ir_out, v.data);
      @(negedge clk); #1;
    end
    bus.ir_ready = 1'b1; bus.br_take = v.br; bus.br_target = v.tgt;
    #1;
    chk($sformatf("v%0d_hs_we", idx), bus.pc_we, 1'b1);
    chk($sformatf("v%0d_hs_inc", idx), bus.pc_inc, !v.br);
    chk($sformatf("v%0d_hs_l", idx), bus.pc_l, v.br);
    chk($sformatf("v%0d_hs_load", idx), bus.pc_load, v.br ? v.tgt : 16'h0000);
    @(negedge clk);
    bus.ir_ready = 1'b0; bus.br_take = 1'b0; bus.br_target = 16'h0000;
    #1;
    chk($sformatf("v%0d_next_valid", idx), bus.ir_valid, 1'b0);
    chk($sformatf("v%0d_next_we", idx), bus.pc_we, 1'b0);
    chk($sformatf("v%0d_next_req", idx), bus.mem_req, 1'b1);
    chk($sformatf("v%0d_next_addr", idx), bus.mem_addr, v.exp_next);
  endtask

  vec_t vecs[5];
  vec_t wv;
  int   req_cycles;

  initial begin
    vecs[0] = '{data: 16'hA5A5, ack_delay: 0,  stall: 0, br: 1'b0, tgt: 16'h0000, exp_addr: 16'h0000, exp_next: 16'h0001};
    vecs[1] = '{data: 16'h1234, ack_delay: 2,  stall: 5, br: 1'b0, tgt: 16'h0000, exp_addr: 16'h0001, exp_next: 16'h0002};
    vecs[2] = '{data: 16'hBEEF, ack_delay: 0,  stall: 0, br: 1'b1, tgt: 16'h0010, exp_addr: 16'h0002, exp_next: 16'h0010};
    vecs[3] = '{data: 16'h0F0F, ack_delay: 1,  stall: 2, br: 1'b1, tgt: 16'h0200, exp_addr: 16'h0010, exp_next: 16'h0200};
    vecs[4] = '{data: 16'hCAFE, ack_delay: 14, stall: 0, br: 1'b0, tgt: 16'h0000, exp_addr: 16'h0200, exp_next: 16'h0201};

    bus.mem_data = 16'h0000; bus.br_target = 16'h0000;
    // Reset state and startup
    pc_init = 16'h0000; pc_clr = 1'b1;
    bus.mem_ack = 1'b1; bus.ir_ready = 1'b1; bus.br_take = 1'b1;
    @(negedge clk); #1;
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_valid", bus.ir_valid, 1'b0);
    chk("rst_fault", bus.fault, 1'b0);
    chk("rst_pcctl", {bus.pc_we, bus.pc_inc, bus.pc_l}, 3'b000);
    chk("rst_load", bus.pc_load, 16'h0000);
    chk("rst_ir", {bus.ir_out, bus.ir_pc}, 32'h0);
    do_reset(16'h0000);
    #1;
    chk("idle_req", bus.mem_req, 1'b0);
    chk("idle_we", bus.pc_we, 1'b0);
    @(negedge clk); #1;
    chk("idle_req2", bus.mem_req, 1'b0);
    @(negedge clk); #1;
    chk("start_req", bus.mem_req, 1'b1);
    chk("start_addr", bus.mem_addr, 16'h0000);

    // Table-driven fetch sequence
    foreach (vecs[i]) begin
      wait_req();
      run_vec(vecs[i], i);
    end

    // Timeout into sticky fault
    do_reset(16'h0040);
    wait_req();
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.mem_req) break;
      req_cycles++;
      @(negedge clk); #1;
    end
    chk("to_req_cycles", req_cycles, TO);
    chk("to_fault", bus.fault, 1'b1);
    bus.mem_ack = 1'b1; bus.mem_data = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("to_sticky%0d", i), {bus.fault, bus.mem_req, bus.ir_valid, bus.pc_we}, 4'b1000);
    end
    bus.mem_ack = 1'b0;
    re = 1'b1; #1;
    chk("to_clear", bus.fault, 1'b0);

    // PC wrap from 16'hFFFF
    do_reset(16'hFFFF);
    wait_req();
    wv = '{data: 16'h1111, ack_delay: 0, stall: 1, br: 1'b0, tgt: 16'h0000, exp_addr: 16'hFFFF, exp_next: 16'h0000};
    run_vec(wv, 9);

    // Async reset mid-fetch, then a late ack while IDLE
    re = 1'b1; #1;
    chk("mid_rst_req", bus.mem_req, 1'b0);
    chk("mid_rst_valid", bus.ir_valid, 1'b0);
    bus.mem_ack = 1'b1; bus.mem_data = 16'h9999;
    @(negedge clk);
    re = 1'b0; #1;
    chk("late_ack_idle", bus.mem_req, 1'b0);
    @(negedge clk);
    bus.mem_ack = 1'b0; #1;
    chk("late_ack_fetch_req", bus.mem_req, 1'b1);
    chk("late_ack_fetch_valid", bus.ir_valid, 1'b0);
    @(negedge clk); #1;
    chk("late_ack_still_fetch", {bus.mem_req, bus.ir_valid}, 2'b10);
    chk("late_ack_ir", bus.ir_out, 16'h0000);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
